// File: rtl/mdu_issue_ctrl.sv
// Issue-side controller for the shared multiply/divide unit and architectural HI/LO.
// Serialises MDU ops of a dual-issue packet (slot 0 first) and stalls until all complete.
module mdu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 33,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        s0_valid,
  input  logic [2:0]  s0_op,
  input  logic [31:0] s0_a,
  input  logic [31:0] s0_b,
  input  logic        s1_valid,
  input  logic [2:0]  s1_op,
  input  logic [31:0] s1_a,
  input  logic [31:0] s1_b,
  output logic        stall,
  output logic        mdu_start,
  output logic [1:0]  mdu_op,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  output logic        mdu_abort,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {StIdle, StRun} state_e;

  localparam logic [CNT_W-1:0] MulCnt = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DivCnt = CNT_W'(DIV_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cur_q, cur_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        pend0, pend1, sel;
  logic [2:0]  sel_op;
  logic [31:0] sel_a, sel_b;
  logic        comp0, comp1;

  assign pend0  = s0_valid && (s0_op <= 3'd5) && !done0_q;
  assign pend1  = s1_valid && (s1_op <= 3'd5) && !done1_q;
  assign sel    = !pend0;
  assign sel_op = sel ? s1_op : s0_op;
  assign sel_a  = sel ? s1_a : s0_a;
  assign sel_b  = sel ? s1_b : s0_b;

  assign hi = hi_q;
  assign lo = lo_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    done0_d   = done0_q;
    done1_d   = done1_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mdu_start = 1'b0;
    mdu_op    = 2'd0;
    mdu_a     = 32'd0;
    mdu_b     = 32'd0;
    mdu_abort = 1'b0;
    comp0     = 1'b0;
    comp1     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pend0 || pend1) begin
          // Pending ops are <= 5, so bit 2 marks MTHI/MTLO
          if (sel_op[2]) begin
            if (sel_op[0]) lo_d = sel_a;
            else           hi_d = sel_a;
            comp0 = !sel;
            comp1 = sel;
          end else begin
            mdu_start = 1'b1;
            mdu_op    = sel_op[1:0];
            mdu_a     = sel_a;
            mdu_b     = sel_b;
            state_d   = StRun;
            cur_d     = sel;
            cnt_d     = sel_op[1] ? DivCnt : MulCnt;
          end
        end
      end
      StRun: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          hi_d    = mdu_hi;
          lo_d    = mdu_lo;
          state_d = StIdle;
          comp0   = !cur_q;
          comp1   = cur_q;
        end
      end
      default: state_d = StIdle;
    endcase

    done0_d = done0_q | comp0;
    done1_d = done1_q | comp1;
    stall   = (pend0 && !comp0) || (pend1 && !comp1);
    if (!stall) begin
      done0_d = 1'b0;
      done1_d = 1'b0;
    end

    // Flush discards everything, including a result arriving this cycle
    if (flush) begin
      state_d   = StIdle;
      cnt_d     = '0;
      done0_d   = 1'b0;
      done1_d   = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      stall     = 1'b0;
      mdu_start = 1'b0;
      mdu_op    = 2'd0;
      mdu_a     = 32'd0;
      mdu_b     = 32'd0;
      mdu_abort = (state_q == StRun);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cur_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Randomized bench for mdu_issue_ctrl: a packet-schedule reference model predicts
// stall/start/abort and HI/LO per cycle; a behavioural MDU supplies timed results.
module tb_mdu_issue_ctrl;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;

  logic        clk, rst, flush;
  logic        s0_valid, s1_valid;
  logic [2:0]  s0_op, s1_op;
  logic [31:0] s0_a, s0_b, s1_a, s1_b;
  logic        stall, mdu_start, mdu_abort;
  logic [1:0]  mdu_op;
  logic [31:0] mdu_a, mdu_b, mdu_hi, mdu_lo, hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  mdu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s0_valid(s0_valid), .s0_op(s0_op), .s0_a(s0_a), .s0_b(s0_b),
    .s1_valid(s1_valid), .s1_op(s1_op), .s1_a(s1_a), .s1_b(s1_b),
    .stall(stall), .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_a(mdu_a), .mdu_b(mdu_b),
    .mdu_abort(mdu_abort), .mdu_hi(mdu_hi), .mdu_lo(mdu_lo), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] mdu_ref(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0: return 64'(sa * sb);
      2'd1: return 64'(ua * ub);
      2'd2: if (b == 0) return {a, 32'hFFFF_FFFF};
            else return {32'(sa % sb), 32'(sa / sb)};
      default: if (b == 0) return {a, 32'hFFFF_FFFF};
               else return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  // Behavioural datapath: result valid only exactly LAT cycles after start
  logic [63:0] dp_res = 64'd0;
  int dp_cnt = 0;
  int dp_lat = -1;
  always @(posedge clk) begin
    if (mdu_start) begin
      dp_res <= mdu_ref(mdu_op, mdu_a, mdu_b);
      dp_cnt <= 1;
      dp_lat <= mdu_op[1] ? DIV_LAT : MUL_LAT;
    end else begin
      dp_cnt <= dp_cnt + 1;
    end
  end
  assign mdu_hi = (dp_cnt == dp_lat) ? dp_res[63:32] : ~dp_res[63:32];
  assign mdu_lo = (dp_cnt == dp_lat) ? dp_res[31:0]  : ~dp_res[31:0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0; flush = 1'b0;
    #1;
    check_eq("idle_stall", {31'd0, stall}, 32'd0);
    check_eq("idle_start", {31'd0, mdu_start}, 32'd0);
    check_eq("idle_hi", hi, mhi);
    check_eq("idle_lo", lo, mlo);
  endtask

  // fl: -1 no flush, -2 random flush cycle, >=0 flush in that packet cycle
  task automatic run_packet(input logic v0, input logic [2:0] op0, input logic [31:0] a0,
                            input logic [31:0] b0, input logic v1, input logic [2:0] op1,
                            input logic [31:0] a1, input logic [31:0] b1, input int fl_in);
    logic [2:0]  kop[2];
    logic [31:0] ka[2], kb[2];
    int ks[2], ke[2];
    int n = 0, t = 0, d, last, fl;
    logic exp_start, exp_abort;
    logic [1:0]  e_op;
    logic [31:0] e_a, e_b;
    if (v0 && op0 <= 3'd5) begin kop[n] = op0; ka[n] = a0; kb[n] = b0; n++; end
    if (v1 && op1 <= 3'd5) begin kop[n] = op1; ka[n] = a1; kb[n] = b1; n++; end
    for (int i = 0; i < n; i++) begin
      ks[i] = t;
      t += (kop[i] >= 3'd4) ? 1 : ((kop[i][1] ? DIV_LAT : MUL_LAT) + 1);
      ke[i] = t - 1;
    end
    d  = (t == 0) ? 1 : t;
    fl = (fl_in == -2) ? int'($urandom_range(0, d - 1)) : fl_in;
    last = (fl >= 0 && fl < d) ? fl : d - 1;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      s0_valid = v0; s0_op = op0; s0_a = a0; s0_b = b0;
      s1_valid = v1; s1_op = op1; s1_a = a1; s1_b = b1;
      flush = (c == fl);
      #1;
      exp_start = 1'b0; exp_abort = 1'b0; e_op = 2'd0; e_a = 32'd0; e_b = 32'd0;
      for (int i = 0; i < n; i++) begin
        if (kop[i] < 3'd4) begin
          if (c == ks[i] && c != fl) begin
            exp_start = 1'b1; e_op = kop[i][1:0]; e_a = ka[i]; e_b = kb[i];
          end
          if (c == fl && c > ks[i] && c <= ke[i]) exp_abort = 1'b1;
        end
      end
      check_eq("stall", {31'd0, stall}, {31'd0, (c < d - 1) && (c != fl)});
      check_eq("mdu_start", {31'd0, mdu_start}, {31'd0, exp_start});
      check_eq("mdu_abort", {31'd0, mdu_abort}, {31'd0, exp_abort});
      check_eq("hi", hi, mhi);
      check_eq("lo", lo, mlo);
      if (exp_start) begin
        check_eq("mdu_op", {30'd0, mdu_op}, {30'd0, e_op});
        check_eq("mdu_a", mdu_a, e_a);
        check_eq("mdu_b", mdu_b, e_b);
      end
      for (int i = 0; i < n; i++) begin
        if (ke[i] == c && c != fl) begin
          if (kop[i] == 3'd4)      mhi = ka[i];
          else if (kop[i] == 3'd5) mlo = ka[i];
          else {mhi, mlo} = mdu_ref(kop[i][1:0], ka[i], kb[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    s0_valid = 1'b0; s0_op = 3'd6; s0_a = 32'd0; s0_b = 32'd0;
    s1_valid = 1'b0; s1_op = 3'd6; s1_a = 32'd0; s1_b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_start", {31'd0, mdu_start}, 32'd0);
    check_eq("rst_abort", {31'd0, mdu_abort}, 32'd0);

    // MULT 7 * -3
    run_packet(1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 3'd6, 32'd0, 32'd0, -1);
    idle_cycle();
    check_eq("mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("mult_lo", lo, 32'hFFFF_FFEB);

    // MTHI then MULTU in the same packet
    run_packet(1'b1, 3'd4, 32'h1234, 32'd0, 1'b1, 3'd1, 32'd2, 32'd3, -1);
    idle_cycle();
    check_eq("mthi_multu_hi", hi, 32'd0);
    check_eq("mthi_multu_lo", lo, 32'd6);

    // DIV then DIVU
    run_packet(1'b1, 3'd2, 32'hFFFF_FF9C, 32'd7, 1'b1, 3'd3, 32'd50, 32'd0, -1);
    idle_cycle();

    // Flush at cnt=5 of a DIV, then a fresh MTLO
    run_packet(1'b1, 3'd2, 32'd1000, 32'd3, 1'b0, 3'd6, 32'd0, 32'd0, DIV_LAT - 5);
    run_packet(1'b1, 3'd5, 32'hCAFE, 32'd0, 1'b0, 3'd6, 32'd0, 32'd0, -1);
    idle_cycle();
    check_eq("flush_mtlo_lo", lo, 32'hCAFE);

    // Non-MDU packet
    run_packet(1'b1, 3'd6, 32'd9, 32'd9, 1'b1, 3'd7, 32'd9, 32'd9, -1);

    // Reset in the middle of a DIVU
    run_packet(1'b1, 3'd4, 32'hAAAA, 32'd0, 1'b1, 3'd5, 32'h5555, 32'd0, -1);
    for (int c = 0; c <= DIV_LAT - 10; c++) begin
      @(negedge clk);
      s0_valid = 1'b1; s0_op = 3'd3; s0_a = 32'd77; s0_b = 32'd5;
      s1_valid = 1'b0;
      rst = (c == DIV_LAT - 10);
      #1;
      check_eq("divu_stall", {31'd0, stall}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b0; s0_valid = 1'b0;
    #1;
    mhi = 32'd0; mlo = 32'd0;
    check_eq("rstrun_hi", hi, 32'd0);
    check_eq("rstrun_lo", lo, 32'd0);
    check_eq("rstrun_stall", {31'd0, stall}, 32'd0);
    repeat (12) idle_cycle();

    // Randomized packets
    for (int p = 0; p < 60; p++) begin
      logic [2:0]  op[2];
      logic        v[2];
      logic [31:0] a[2], b[2];
      int r;
      for (int k = 0; k < 2; k++) begin
        r    = int'($urandom_range(0, 9));
        op[k] = (r < 8) ? 3'(r) : ((r == 8) ? 3'd4 : 3'd5);
        v[k] = ($urandom_range(0, 3) != 0);
        a[k] = $urandom;
        b[k] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      end
      run_packet(v[0], op[0], a[0], b[0], v[1], op[1], a[1], b[1],
                 ($urandom_range(0, 3) == 0) ? -2 : -1);
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
Controller for the shared multiply/divide unit and the HI/LO register pair in the dual-issue execute stage.
- Takes MDU-class ops from both issue slots and serialises them in program order: slot 0 first, then slot 1.
- Sequences the external MDU datapath with start/latency counting and owns the architectural HI/LO.
- Stalls the issue packet until every MDU op in it has completed.

Parameters:
MUL_LAT, 3, cycles from mdu_start to valid multiply result (>=1)
DIV_LAT, 33, cycles from mdu_start to valid divide result (>=1)
CNT_W, 6, counter width; must hold max(MUL_LAT,DIV_LAT)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush; aborts the current packet
s0_valid  in  1  slot 0 holds a valid instruction
s0_op  in  3  slot 0 MDU op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 none
s0_a  in  32  slot 0 rs operand (already bypassed)
s0_b  in  32  slot 0 rt operand (already bypassed)
s1_valid, s1_op, s1_a, s1_b  in  1/3/32/32  same meanings for slot 1
stall  out  1  hold issue/execute packet this cycle
mdu_start  out  1  one-cycle start pulse to MDU datapath
mdu_op  out  2  op to datapath (MULT..DIVU encoding)
mdu_a  out  32  datapath operand A
mdu_b  out  32  datapath operand B
mdu_abort  out  1  one-cycle pulse; cancels in-flight datapath op
mdu_hi  in  32  datapath HI result, valid in capture cycle
mdu_lo  in  32  datapath LO result, valid in capture cycle
hi  out  32  architectural HI
lo  out  32  architectural LO

Behaviour:
- Slot k is pending when sk_valid, sk_op<=5 and done_k=0. Current slot = lowest-numbered pending slot.
- States: IDLE and RUN. Registers: state, cnt, cur (slot served), done0, done1, hi, lo.
- Reset: state=IDLE, cnt=0, done0=done1=0, hi=lo=0. Outputs: stall=0, mdu_start=0, mdu_abort=0. mdu_op/mdu_a/mdu_b=0.
- IDLE, current slot is MTHI/MTLO:
  - Write sk_a into hi (MTHI) or lo (MTLO) at the clock edge.
  - Set done_k; stay IDLE. Single cycle, no datapath activity.
- IDLE, current slot is MULT..DIVU:
  - Combinationally drive mdu_start=1, mdu_op=op[1:0], mdu_a=sk_a, mdu_b=sk_b.
  - At the edge: state=RUN, cur=k, cnt=LAT-1, where LAT is MUL_LAT for ops 0/1 and DIV_LAT for ops 2/3.
- RUN, cnt!=0: cnt decrements; mdu_start=0.
- RUN, cnt==0 (capture cycle):
  - At the edge: hi<=mdu_hi, lo<=mdu_lo, done_cur=1, state=IDLE.
  - Result is therefore visible on hi/lo LAT+1 cycles after the mdu_start cycle.
- Completion rule: the op completes this cycle if it is MTHI/MTLO in IDLE, or if the state is RUN with cnt==0.
- stall=1 iff a pending op remains after excluding the one completing this cycle. stall is combinational.
- The packet advances when stall=0. Any cycle with stall=0 clears done0/done1 at the edge.
- When both slots target HI/LO, slot 1 sees slot 0's write: the writes are serialised and operands are taken at issue.
- Divide by zero: no special handling; the datapath result is captured as delivered.
- flush (priority below rst, above everything else):
  - state=IDLE, done flags cleared, no HI/LO write in that cycle (including a capture cycle), stall=0, mdu_start=0.
  - mdu_abort=1 for that cycle if state was RUN.
- sk_op/sk_a/sk_b must stay stable while stall=1. The controller re-reads them only at mdu_start and MTHI/MTLO.
- Back-to-back packets: a new op may start in the IDLE cycle immediately after a capture.

Test Plan:
- rst mid-RUN: DIVU started, rst at cnt=10 -> next cycle state IDLE, hi=lo=0, stall=0, no capture.
- MULT alone: s0 MULT a=7 b=-3, MUL_LAT=3 -> mdu_start cycle 0; stall=1 cycles 0-2, 0 in cycle 3 (capture). Model returns hi=FFFFFFFF lo=FFFFFFEB -> regs hold them from cycle 4.
- Dual MTHI/MULTU: s0 MTHI a=0x1234, s1 MULTU a=2 b=3 -> cycle 0: hi<=0x1234, stall=1; cycle 1: mdu_start with a=2 b=3; capture cycle 4 (stall=0). Final hi=0, lo=6.
- Dual DIV: s0 DIV, s1 DIVU, DIV_LAT=33 -> first start cycle 0, capture 33; second start 34, capture 67. stall=0 only in cycle 67; mdu_start pulses exactly twice.
- Flush: flush at cnt=5 during DIV -> mdu_abort=1 and stall=0 that cycle, hi/lo unchanged; a fresh MTLO next cycle writes lo immediately.
- Non-MDU packet: s0_op=6, s1_op=7, both valid -> stall=0, mdu_start=0, hi/lo unchanged.
